// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_scan_ctrl display controller: hex font,
// blank segment pattern and prescaler sizing helpers.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low patterns, bit 0 = segment a .. bit 6 = segment g.
    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int calc_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/seg7_font.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_font
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = FONT[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with frame-synchronous update.
// Optional PWM dimming of the anode drive is compiled in with SEG7_DIM_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIG      = 4,
    parameter int CLK_HZ     = 50000000,
    parameter int SCAN_HZ    = 1000,
    parameter int AN_ACT_LOW = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*N_DIG-1:0] dat,
    input  logic [N_DIG-1:0]   dp,
    input  logic [N_DIG-1:0]   blank,
    input  logic               lz_en,
    input  logic               upd_req,
    output logic               upd_ack,
    input  logic [2:0]         bright,
    output logic               ce1ms,
    output logic               frame_end,
    output logic [N_DIG-1:0]   AN,
    output logic [7:0]         SEG
);

    localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
    localparam int CW  = div_width(DIV);
    localparam int IW  = $clog2(N_DIG);

    localparam logic [CW-1:0]    CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0]    IDX_MAX = IW'(N_DIG - 1);
    localparam logic [N_DIG-1:0] AN_ONE  = N_DIG'(1);
    localparam logic [N_DIG-1:0] AN_IDLE = {N_DIG{AN_ACT_LOW != 0}};

    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_next;
    logic [IW-1:0]      idx;
    logic [4*N_DIG-1:0] pend_dat;
    logic [4*N_DIG-1:0] act_dat;
    logic [N_DIG-1:0]   pend_dp;
    logic [N_DIG-1:0]   act_dp;
    logic [N_DIG-1:0]   pend_blank;
    logic [N_DIG-1:0]   act_blank;
    logic               pend_flag;
    logic [N_DIG-1:0]   an_sel;
    logic [N_DIG-1:0]   sel_next;
    logic [N_DIG-1:0]   gate;
    logic [3:0]         cur_nib;
    logic               cur_dp;
    logic               cur_blank;
    logic               lz_zero;
    logic               dark;
    logic [6:0]         font_seg;
    logic [7:0]         seg_next;

    assign ce1ms     = (cnt == CNT_MAX);
    assign frame_end = ce1ms && (idx == IDX_MAX);
    assign cnt_next  = ce1ms ? '0 : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_next;
            if (ce1ms)
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
    end

    // A request landing on the wrap itself bypasses pending so that the
    // frame starting at this wrap already shows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dat   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            act_dat    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pend_flag  <= 1'b0;
            upd_ack    <= 1'b0;
        end else begin
            upd_ack <= 1'b0;
            if (upd_req && frame_end) begin
                act_dat   <= dat;
                act_dp    <= dp;
                act_blank <= blank;
                pend_flag <= 1'b0;
                upd_ack   <= 1'b1;
            end else if (frame_end && pend_flag) begin
                act_dat   <= pend_dat;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
                pend_flag <= 1'b0;
                upd_ack   <= 1'b1;
            end else if (upd_req) begin
                pend_dat   <= dat;
                pend_dp    <= dp;
                pend_blank <= blank;
                pend_flag  <= 1'b1;
            end
        end
    end

    always_comb begin
        cur_nib   = act_dat[idx*4 +: 4];
        cur_dp    = act_dp[idx];
        cur_blank = act_blank[idx];
        lz_zero   = 1'b1;
        for (int j = 0; j < N_DIG; j++) begin
            if (j >= int'(idx) && act_dat[j*4 +: 4] != 4'h0)
                lz_zero = 1'b0;
        end
        dark     = cur_blank || (lz_en && (idx != '0) && lz_zero);
        seg_next = {(~cur_dp) | cur_blank, dark ? 7'h7F : font_seg};
    end

    seg7_font u_font (
        .nib (cur_nib),
        .seg (font_seg)
    );

`ifdef SEG7_DIM_EN
    localparam int PH = DIV / 8;

    // Gate is evaluated for the slot position the outputs are about to show.
    always_comb begin
        gate = '0;
        if (bright == 3'd7 || int'(cnt_next) < (int'(bright) + 1) * PH)
            gate = '1;
    end
`else
    logic unused_bright;

    assign unused_bright = ^bright;
    assign gate          = '1;
`endif

    assign sel_next = ce1ms ? (AN_ONE << idx) : an_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_sel <= '0;
            AN     <= AN_IDLE;
            SEG    <= SEG_OFF;
        end else begin
            an_sel <= sel_next;
            AN     <= (AN_ACT_LOW != 0) ? ~(sel_next & gate) : (sel_next & gate);
            if (ce1ms)
                SEG <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus random updates
// against a slot/frame-level reference model. Define SEG7_DIM_EN to check dimming.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

    localparam int N = 4;
`ifdef SEG7_DIM_EN
    localparam int CLK_HZ = 1600;
`else
    localparam int CLK_HZ = 1000;
`endif
    localparam int SCAN_HZ = 100;
    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int FRAME   = N * DIV;
    localparam logic [N-1:0] AN_IDLE = '1;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b1;
    logic [4*N-1:0] dat     = '0;
    logic [N-1:0]   dp      = '0;
    logic [N-1:0]   blank   = '0;
    logic           lz_en   = 1'b0;
    logic           upd_req = 1'b0;
    logic [2:0]     bright  = 3'd7;
    logic           upd_ack;
    logic           ce1ms;
    logic           frame_end;
    logic [N-1:0]   AN;
    logic [7:0]     SEG;

    seg7_scan_ctrl #(
        .N_DIG      (N),
        .CLK_HZ     (CLK_HZ),
        .SCAN_HZ    (SCAN_HZ),
        .AN_ACT_LOW (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dat       (dat),
        .dp        (dp),
        .blank     (blank),
        .lz_en     (lz_en),
        .upd_req   (upd_req),
        .upd_ack   (upd_ack),
        .bright    (bright),
        .ce1ms     (ce1ms),
        .frame_end (frame_end),
        .AN        (AN),
        .SEG       (SEG)
    );

    always #5 clk = ~clk;

    // Lit segments of each hex glyph, named by segment letter.
    string LIT [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    int             checks = 0;
    int             errors = 0;
    int             cyc;
    logic [4*N-1:0] m_dat, p_dat;
    logic [N-1:0]   m_dp, m_blank, p_dp, p_blank;
    bit             m_pend, m_ack;
    int             m_digit;
    int             m_bright;
    logic [7:0]     m_seg;

    function automatic logic [6:0] fontRef(input int h);
        string      s;
        logic [6:0] res;
        s   = LIT[h];
        res = 7'h7F;
        for (int i = 0; i < s.len(); i++)
            res[int'(s[i]) - 97] = 1'b0;
        return res;
    endfunction

    function automatic logic [7:0] segFor(input int d);
        logic [3:0] nib;
        bit         dark;
        nib  = 4'((m_dat >> (4 * d)) & 16'hF);
        dark = m_blank[d] || (lz_en && d != 0 && ((m_dat >> (4 * d)) == '0));
        return {m_blank[d] ? 1'b1 : ~m_dp[d], dark ? 7'h7F : fontRef(int'(nib))};
    endfunction

    function automatic logic [N-1:0] expAn();
        logic [N-1:0] one;
        bit           lit;
        one = 1;
        lit = 1'b1;
`ifdef SEG7_DIM_EN
        lit = (m_bright == 7) || ((cyc % DIV) < (m_bright + 1) * (DIV / 8));
`endif
        if (m_digit < 0 || !lit)
            return AN_IDLE;
        return ~(one << m_digit);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        cyc     = 0;
        m_dat   = '0; m_dp = '0; m_blank = '0;
        p_dat   = '0; p_dp = '0; p_blank = '0;
        m_pend  = 0;
        m_ack   = 0;
        m_digit = -1;
        m_seg   = 8'hFF;
    endtask

    // Called right after a rising edge with the inputs that were presented to it.
    task automatic modelEdge();
        bit tick, fe;
        int d;
        tick = (cyc % DIV) == DIV - 1;
        d    = (cyc / DIV) % N;
        fe   = tick && d == N - 1;
        if (tick) begin
            m_digit = d;
            m_seg   = segFor(d);
        end
        m_ack = 0;
        if (upd_req && fe) begin
            m_dat = dat; m_dp = dp; m_blank = blank;
            m_pend = 0; m_ack = 1;
        end else if (fe && m_pend) begin
            m_dat = p_dat; m_dp = p_dp; m_blank = p_blank;
            m_pend = 0; m_ack = 1;
        end else if (upd_req) begin
            p_dat = dat; p_dp = dp; p_blank = blank;
            m_pend = 1;
        end
        m_bright = int'(bright);
        cyc++;
    endtask

    task automatic runCycle();
        checkOutput("ce1ms", ce1ms, (cyc % DIV) == DIV - 1);
        checkOutput("frame_end", frame_end, ((cyc % DIV) == DIV - 1) && (((cyc / DIV) % N) == N - 1));
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("AN", AN, expAn());
        checkOutput("SEG", SEG, m_seg);
        checkOutput("upd_ack", upd_ack, m_ack);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++)
            runCycle();
    endtask

    task automatic runUntilFrameEnd();
        while (!(((cyc % DIV) == DIV - 1) && (((cyc / DIV) % N) == N - 1)))
            runCycle();
    endtask

    task automatic applyStimulus(input logic [4*N-1:0] d, input logic [N-1:0] p, input logic [N-1:0] b);
        dat     = d;
        dp      = p;
        blank   = b;
        upd_req = 1'b1;
        runCycle();
        upd_req = 1'b0;
    endtask

    task automatic resetDut();
        rst_n   = 1'b0;
        upd_req = 1'b0;
        #1;
        checkOutput("rst_AN", AN, AN_IDLE);
        checkOutput("rst_SEG", SEG, 8'hFF);
        checkOutput("rst_upd_ack", upd_ack, 1'b0);
        checkOutput("rst_ce1ms", ce1ms, 1'b0);
        checkOutput("rst_frame_end", frame_end, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_bright = int'(bright);
        modelReset();
    endtask

    initial begin
        int on_cnt [N];
        logic [N-1:0] one;
        one = 1;

        #2;
        resetDut();
        runCycles(45);

        runCycles(3);
        applyStimulus(16'h12AF, 4'b0100, 4'b0000);
        runCycles(2 * FRAME);

        runUntilFrameEnd();
        runCycle();
        applyStimulus(16'h1111, 4'b0000, 4'b0000);
        runCycles(5);
        applyStimulus(16'h2222, 4'b0000, 4'b0000);
        runCycles(2 * FRAME);

        lz_en = 1'b1;
        applyStimulus(16'h0050, 4'b0000, 4'b0000);
        runCycles(2 * FRAME);
        applyStimulus(16'h0000, 4'b0000, 4'b0000);
        runCycles(2 * FRAME);
        lz_en = 1'b0;

        runUntilFrameEnd();
        applyStimulus(16'hBEEF, 4'b0000, 4'b0000);
        runCycles(2 * FRAME);

        for (int k = 0; k < 20; k++) begin
            lz_en  = 1'($urandom_range(0, 1));
            bright = 3'($urandom_range(0, 7));
            applyStimulus(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
            runCycles($urandom_range(1, 60));
        end
        lz_en = 1'b0;
        runCycles(2 * FRAME);

        runUntilFrameEnd();
        runCycle();
        applyStimulus(16'hA5C3, 4'b1010, 4'b0000);
        runCycles(5);
        resetDut();
        runCycles(2 * FRAME);

        // Per-digit on-time across one aligned frame of slots.
        bright = 3'd1;
        applyStimulus(16'h8888, 4'b0000, 4'b0010);
        runCycles(2 * FRAME);
        runUntilFrameEnd();
        runCycle();
        for (int d = 0; d < N; d++)
            on_cnt[d] = 0;
        for (int k = 0; k < FRAME; k++) begin
            for (int d = 0; d < N; d++)
                if (AN === ~(one << d))
                    on_cnt[d]++;
            runCycle();
        end
        for (int d = 0; d < N; d++) begin
`ifdef SEG7_DIM_EN
            checkOutput($sformatf("on_time_d%0d", d), on_cnt[d], 2 * (DIV / 8));
`else
            checkOutput($sformatf("on_time_d%0d", d), on_cnt[d], DIV);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
